// File: rtl/fb_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : fb_reader_if
//  Description : Bundles the Wishbone classic read-master bus and the
//                valid/ready pixel stream of the framebuffer reader.
//                master modport : framebuffer reader side
//                slave  modport : memory / display side
//  Ports       : wshb_*  Wishbone classic (read only, no err/rty)
//                pix_*   show-ahead pixel stream
//  Revision    : 1.0  initial release
// ============================================================================
interface fb_reader_if;
    logic [31:0] wshb_adr;
    logic [31:0] wshb_dat_sm;
    logic        wshb_we;
    logic [3:0]  wshb_sel;
    logic [2:0]  wshb_cti;
    logic [1:0]  wshb_bte;
    logic        wshb_cyc;
    logic        wshb_stb;
    logic        wshb_ack;

    logic [23:0] pix_data;
    logic        pix_sof;
    logic        pix_eol;
    logic        pix_valid;
    logic        pix_ready;

    modport master (
        output wshb_adr, wshb_we, wshb_sel, wshb_cti, wshb_bte,
               wshb_cyc, wshb_stb,
        input  wshb_dat_sm, wshb_ack,
        output pix_data, pix_sof, pix_eol, pix_valid,
        input  pix_ready
    );

    modport slave (
        input  wshb_adr, wshb_we, wshb_sel, wshb_cti, wshb_bte,
               wshb_cyc, wshb_stb,
        output wshb_dat_sm, wshb_ack,
        input  pix_data, pix_sof, pix_eol, pix_valid,
        output pix_ready
    );
endinterface
`default_nettype wire

// File: rtl/fb_reader.sv
`default_nettype none
// ============================================================================
//  Module      : fb_reader
//  Description : Framebuffer reader. Wishbone classic read master fetching
//                HDISP x VDISP 32-bit pixel words (row-major) into a small
//                FIFO, delivered as a show-ahead valid/ready pixel stream
//                tagged with start-of-frame and end-of-line. The bus is
//                released after at most BURST words so other masters can
//                be arbitrated.
//  Ports       : clk, rst_n   clock, asynchronous active-low reset
//                enable       run request; low returns to idle and flushes
//                bus          fb_reader_if.master (Wishbone + pixel stream)
//                fifo_level   current FIFO occupancy
//  Revision    : 1.0  initial release
// ============================================================================
module fb_reader #(
    parameter int          HDISP      = 800,
    parameter int          VDISP      = 480,
    parameter logic [31:0] BASE_ADR   = 32'h0,
    parameter int          FIFO_DEPTH = 16,
    parameter int          BURST      = 8
) (
    input  wire logic                        clk,
    input  wire logic                        rst_n,
    input  wire logic                        enable,
    fb_reader_if.master                      bus,
    output logic [$clog2(FIFO_DEPTH):0]      fifo_level
);

    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int NWORDS = HDISP * VDISP;
    localparam int IW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int XW     = (HDISP > 1) ? $clog2(HDISP) : 1;
    localparam int YW     = (VDISP > 1) ? $clog2(VDISP) : 1;
    localparam int BW     = $clog2(BURST + 1);

    localparam logic [IW-1:0] IDX_LAST = IW'(NWORDS - 1);
    localparam logic [XW-1:0] X_LAST   = XW'(HDISP - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(VDISP - 1);
    localparam logic [BW-1:0] BURST_N  = BW'(BURST);
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            cyc_q, cyc_d;          // cyc and stb are always equal
    logic [IW-1:0]   idx_q, idx_d;
    logic [BW-1:0]   burst_q, burst_d;
    logic [AW-1:0]   wr_q, wr_d;
    logic [AW-1:0]   rd_q, rd_d;
    logic [AW:0]     level_q, level_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic [23:0]     mem [FIFO_DEPTH];

    logic            push;
    logic            pop;
    logic            pix_valid_w;
    logic            unused_dat_hi;

    // Only the low 24 bits of a pixel word carry colour.
    assign unused_dat_hi = ^bus.wshb_dat_sm[31:24];

    assign pix_valid_w = (level_q != '0);
    assign push        = cyc_q & bus.wshb_ack;
    assign pop         = pix_valid_w & bus.pix_ready;

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        idx_d   = idx_q;
        burst_d = burst_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        x_d     = x_q;
        y_d     = y_q;
        level_d = level_q + (AW+1)'(push) - (AW+1)'(pop);

        if (push) begin
            wr_d    = wr_q + 1'b1;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            burst_d = burst_q + 1'b1;
        end

        if (pop) begin
            rd_d = rd_q + 1'b1;
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                cyc_d = 1'b0;
                if (enable) state_d = S_REQ;
            end
            S_REQ: begin
                if (push) begin
                    // A tenure ends on burst length, a full FIFO, the frame
                    // boundary, or a stop request -- always on an ack.
                    if ((burst_d == BURST_N) || (level_d == LVL_FULL) ||
                        (idx_q == IDX_LAST) || !enable) begin
                        state_d = S_GAP;
                        cyc_d   = 1'b0;
                    end
                end else if (!cyc_q) begin
                    // First cycle after leaving idle: raise the strobe now.
                    if (enable) cyc_d   = 1'b1;
                    else        state_d = S_GAP;
                end
            end
            S_GAP: begin
                cyc_d   = 1'b0;
                burst_d = '0;
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (level_q < LVL_FULL) begin
                    state_d = S_REQ;
                    cyc_d   = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cyc_d   = 1'b0;
            end
        endcase

        // Entering or sitting in idle flushes the FIFO and rewinds the frame.
        if (state_d == S_IDLE) begin
            idx_d   = '0;
            burst_d = '0;
            wr_d    = '0;
            rd_d    = '0;
            level_d = '0;
            x_d     = '0;
            y_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cyc_q   <= 1'b0;
            idx_q   <= '0;
            burst_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            idx_q   <= idx_d;
            burst_q <= burst_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_q] <= bus.wshb_dat_sm[23:0];
    end

    assign bus.wshb_adr = BASE_ADR + (32'(idx_q) << 2);
    assign bus.wshb_we  = 1'b0;
    assign bus.wshb_sel = 4'b1111;
    assign bus.wshb_cti = 3'b000;
    assign bus.wshb_bte = 2'b00;
    assign bus.wshb_cyc = cyc_q;
    assign bus.wshb_stb = cyc_q;

    assign bus.pix_valid = pix_valid_w;
    assign bus.pix_data  = pix_valid_w ? mem[rd_q] : 24'h0;
    assign bus.pix_sof   = pix_valid_w && (x_q == '0) && (y_q == '0);
    assign bus.pix_eol   = pix_valid_w && (x_q == X_LAST);

    assign fifo_level = level_q;

endmodule
`default_nettype wire

// File: tb/tb_fb_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fb_reader
//  Description : Directed self-checking bench for fb_reader with an 8x4
//                frame, 16-word FIFO and 8-word bursts. A Wishbone slave
//                model returns a known word per address with programmable
//                ack latency; monitors check addresses, wait-state
//                stability and the pixel stream against a frame model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fb_reader;

    localparam int          H     = 8;
    localparam int          V     = 4;
    localparam int          NW    = H * V;
    localparam logic [31:0] BASE  = 32'h0000_0100;
    localparam int          DEPTH = 16;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [4:0]  fifo_level;

    fb_reader_if bus();

    fb_reader #(
        .HDISP      (H),
        .VDISP      (V),
        .BASE_ADR   (BASE),
        .FIFO_DEPTH (DEPTH),
        .BURST      (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .bus        (bus),
        .fifo_level (fifo_level)
    );

    int n_tests;
    int n_fail;
    int lat;
    int wait_cnt;
    int exp_p;
    int exp_w;
    int n_acks;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] word_data(input int w);
        logic [31:0] t;
        t = 32'(w) * 32'h0001_0307 + 32'h5A;
        return {8'hC3, t[23:0]};
    endfunction

    function automatic int adr_word(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wishbone slave: data is a function of the word address, ack after
    // 'lat' wait states.
    assign bus.wshb_dat_sm = word_data(adr_word(bus.wshb_adr));
    assign bus.wshb_ack    = bus.wshb_cyc & bus.wshb_stb & (wait_cnt >= lat);

    always @(posedge clk)
        wait_cnt <= (bus.wshb_cyc & bus.wshb_stb & !bus.wshb_ack) ? wait_cnt + 1 : 0;

    // Mid-cycle monitors: bus addresses, wait-state stability, overflow
    // guard and the pixel stream.
    initial begin : mon
        logic        hold_pend;
        logic [31:0] hold_adr;
        logic [31:0] d;
        hold_pend = 1'b0;
        hold_adr  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_pend = 1'b0;
            end else begin
                if (hold_pend) begin
                    check("hold_stb", bus.wshb_stb, 1'b1);
                    check("hold_adr", bus.wshb_adr, hold_adr);
                end
                hold_pend = bus.wshb_cyc & bus.wshb_stb & !bus.wshb_ack;
                hold_adr  = bus.wshb_adr;

                if (bus.wshb_cyc && bus.wshb_stb && bus.wshb_ack) begin
                    check("ack_adr", bus.wshb_adr, BASE + 32'(exp_w) * 4);
                    exp_w  = (exp_w + 1) % NW;
                    n_acks++;
                end

                if (fifo_level == 5'(DEPTH))
                    check("stb_when_full", bus.wshb_stb, 1'b0);

                if (bus.pix_valid && bus.pix_ready) begin
                    d = word_data(exp_p);
                    check("pix_data", bus.pix_data, d[23:0]);
                    check("pix_sof", bus.pix_sof, exp_p == 0);
                    check("pix_eol", bus.pix_eol, (exp_p % H) == (H - 1));
                    exp_p = (exp_p + 1) % NW;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic quiesce();
        enable = 1'b0;
        repeat (12) tick();
        check("idle_cyc", bus.wshb_cyc, 1'b0);
        check("idle_valid", bus.pix_valid, 1'b0);
        check("idle_level", fifo_level, 5'd0);
        exp_p  = 0;
        exp_w  = 0;
        n_acks = 0;
    endtask

    initial begin
        bit found;
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        enable  = 1'b0;
        lat     = 0;
        exp_p   = 0;
        exp_w   = 0;
        n_acks  = 0;
        bus.pix_ready = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_cyc", bus.wshb_cyc, 1'b0);
        check("rst_stb", bus.wshb_stb, 1'b0);
        check("rst_adr", bus.wshb_adr, BASE);
        check("rst_valid", bus.pix_valid, 1'b0);
        check("rst_sof", bus.pix_sof, 1'b0);
        check("rst_eol", bus.pix_eol, 1'b0);
        check("rst_data", bus.pix_data, 24'h0);
        check("rst_level", fifo_level, 5'd0);
        check("const_we", bus.wshb_we, 1'b0);
        check("const_sel", bus.wshb_sel, 4'hF);
        check("const_cti", bus.wshb_cti, 3'd0);
        check("const_bte", bus.wshb_bte, 2'd0);
        rst_n = 1'b1;
        tick();

        // Zero-wait bursts, consumer always ready
        bus.pix_ready = 1'b1;
        enable        = 1'b1;
        tick();
        check("t1_cyc_first_edge", bus.wshb_cyc, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t1_cyc", bus.wshb_cyc, 1'b1);
            check("t1_adr", bus.wshb_adr, BASE + 32'(i) * 4);
            if (i == 1) begin
                check("t1_first_valid", bus.pix_valid, 1'b1);
                check("t1_first_sof", bus.pix_sof, 1'b1);
            end
            if (i == 4) check("t1_level_pushpop", fifo_level, 5'd1);
        end
        tick();
        check("t1_gap_cyc", bus.wshb_cyc, 1'b0);
        tick();
        check("t1_cyc2", bus.wshb_cyc, 1'b1);
        check("t1_adr2", bus.wshb_adr, BASE + 32);
        repeat (50) tick();
        check("t1_frame_wrapped", n_acks > NW, 1'b1);
        quiesce();

        // Back-pressure: FIFO fills, fetching stops, then resumes
        bus.pix_ready = 1'b0;
        enable        = 1'b1;
        repeat (40) tick();
        check("t2_acks", n_acks, 32'd16);
        check("t2_level", fifo_level, 5'd16);
        check("t2_stb", bus.wshb_stb, 1'b0);
        check("t2_valid", bus.pix_valid, 1'b1);
        check("t2_sof_head", bus.pix_sof, 1'b1);
        bus.pix_ready = 1'b1;
        repeat (30) tick();
        check("t2_resumed", n_acks > 16, 1'b1);
        quiesce();

        // Three wait states per transfer
        lat           = 3;
        bus.pix_ready = 1'b1;
        enable        = 1'b1;
        repeat (60) tick();
        check("t3_acks", n_acks >= 10, 1'b1);

        // Stop request while a transfer waits for ack
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (bus.wshb_stb && wait_cnt == 0) found = 1'b1;
        end
        check("t4_found_wait", found, 1'b1);
        bus.pix_ready = 1'b0;
        enable        = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_cyc_held", bus.wshb_cyc, 1'b1);
        end
        tick();
        check("t4_gap_cyc", bus.wshb_cyc, 1'b0);
        check("t4_gap_valid", bus.pix_valid, 1'b1);
        tick();
        check("t4_flushed_valid", bus.pix_valid, 1'b0);
        check("t4_flushed_level", fifo_level, 5'd0);
        exp_p  = 0;
        exp_w  = 0;
        n_acks = 0;

        // Re-enable restarts at the base address
        lat           = 0;
        bus.pix_ready = 1'b1;
        enable        = 1'b1;
        tick();
        tick();
        check("t4_restart_cyc", bus.wshb_cyc, 1'b1);
        check("t4_restart_adr", bus.wshb_adr, BASE);

        // Asynchronous reset in the middle of a burst
        tick();
        tick();
        check("t5_pre_cyc", bus.wshb_cyc, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("t5_async_cyc", bus.wshb_cyc, 1'b0);
        check("t5_async_stb", bus.wshb_stb, 1'b0);
        check("t5_async_valid", bus.pix_valid, 1'b0);
        check("t5_async_level", fifo_level, 5'd0);
        check("t5_async_adr", bus.wshb_adr, BASE);
        tick();
        exp_p  = 0;
        exp_w  = 0;
        n_acks = 0;
        rst_n  = 1'b1;
        tick();
        check("t5_first_edge_cyc", bus.wshb_cyc, 1'b0);
        tick();
        check("t5_restart_cyc", bus.wshb_cyc, 1'b1);
        check("t5_restart_adr", bus.wshb_adr, BASE);
        repeat (50) tick();
        check("t5_running", n_acks > 30, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fb_reader.md
# fb_reader

Framebuffer reader: Wishbone classic read master that fetches one frame of 32-bit pixel words (HDISP×VDISP, row-major, one word per pixel) from video memory and delivers them through an internal FIFO as a valid/ready pixel stream. It sits between the SDRAM Wishbone interconnect and the display-timing side of the video controller, and reads back the framebuffer filled by the test-pattern writer. It releases the bus periodically so that other masters can be arbitrated.

## Interface
- HDISP, 800, pixels per line
- VDISP, 480, lines per frame
- BASE_ADR, 32'h0, byte address of pixel (0,0)
- FIFO_DEPTH, 16, pixel FIFO depth in words (power of two, ≥4)
- BURST, 8, maximum words fetched per bus tenure (cyc held)
- clk  in  1  single system clock; all logic on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  run request; low returns the block to idle
- wshb_adr  out  32  byte address = BASE_ADR + 4·word_index
- wshb_dat_sm  in  32  read data from slave
- wshb_we  out  1  constant 0
- wshb_sel  out  4  constant 4'b1111
- wshb_cti  out  3  constant 0 (classic cycle)
- wshb_bte  out  2  constant 0
- wshb_cyc  out  1  bus tenure
- wshb_stb  out  1  transfer strobe
- wshb_ack  in  1  slave acknowledge; data valid in same cycle
- pix_data  out  24  wshb_dat_sm[23:0] of FIFO head word
- pix_sof  out  1  head pixel is (0,0)
- pix_eol  out  1  head pixel is x = HDISP-1
- pix_valid  out  1  FIFO not empty
- pix_ready  in  1  consumer accepts head when pix_valid & pix_ready
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- States: IDLE, REQ, GAP.
- IDLE: cyc=stb=0, word_index=0, FIFO empty, pixel counters x=y=0. enable=1 → REQ.
- REQ: cyc=stb=1, adr driven from word_index. On ack: push wshb_dat_sm into FIFO, word_index+1 (wraps from HDISP·VDISP-1 to 0), burst_cnt+1.
- Leave REQ → GAP, taken on the ack cycle, when: burst_cnt reaches BURST; or the FIFO becomes full after this push; or word_index wraps (a tenure never crosses a frame boundary); or enable=0.
- Without ack in REQ, cyc/stb/adr stay stable; enable=0 does not abort an outstanding transfer.
- GAP: cyc=stb=0 for at least one cycle; burst_cnt cleared. Go to REQ when enable=1 and fifo_level < FIFO_DEPTH; go to IDLE (with flush) when enable=0.
- Only one transfer is outstanding (classic); stb is never asserted while fifo_level = FIFO_DEPTH, so the FIFO cannot overflow.
- Stream side: pop on pix_valid & pix_ready; x increments, wraps at HDISP-1 and increments y, which wraps at VDISP-1. pix_sof = (x==0 && y==0), pix_eol = (x==HDISP-1), both qualified by pix_valid.
- Simultaneous push and pop: fifo_level unchanged, both happen.
- wshb_err/rty are not supported.

## Timing
- Reset values: cyc=0, stb=0, adr=BASE_ADR, pix_valid=0, pix_sof=0, pix_eol=0, pix_data=0, fifo_level=0; state IDLE.
- enable sampled high at edge k → cyc=stb=1 and adr=BASE_ADR after edge k+1.
- Ack at edge n → fifo_level updated and pix_valid=1 (if it was empty) after edge n. The next adr (or cyc=0) is also visible after edge n, giving zero-wait back-to-back transfers with continuously acking slaves.
- Burst throughput with a 1-cycle ack: BURST words in BURST cycles, then ≥1 GAP cycle.
- pix_data/pix_sof/pix_eol are valid combinationally from the FIFO head register (show-ahead); pop takes effect at the edge.
- rst_n asserted mid-transfer: all outputs return to reset values immediately (asynchronous); the first cycle after release starts from word 0.

## Test plan
- Reset then enable=1, slave acks every cycle, pix_ready=1, BURST=8: adr sequence 0,4,…,28, cyc low for 1 cycle, then 32…; first pix_valid one cycle after first ack with pix_sof=1.
- pix_ready=0, FIFO_DEPTH=16: exactly 16 acks accepted, stb stays low; fifo_level=16. Raise pix_ready: 16 pixels out in order, fetching resumes.
- Slave with 3-cycle ack latency: adr/stb stable through the wait states, each data word pushed once, no duplicates.
- Full frame with HDISP=8, VDISP=4: pix_eol on every 8th pixel, pix_sof on pixels 0 and 32. After word 31, adr wraps to BASE_ADR and a new tenure starts.
- enable dropped while stb is waiting for ack: cyc held until ack, then GAP→IDLE, FIFO flushed (pix_valid=0). Re-enable restarts at BASE_ADR.
- rst_n pulsed low mid-burst: cyc/stb/pix_valid go 0 without a clock edge; restart fetches from word 0.
